// File: rtl/nmr_echo_packer_pkg.sv
// Shared types and constants for the NMR echo packer: FSM states and word-format tags.
package nmr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    ACQ,
    DONE
  } state_t;

  localparam logic [15:0] HEADER_TAG    = 16'hEC40;
  localparam logic [15:0] PAD_WORD_HALF = 16'h0000;

endpackage

// File: rtl/nmr_echo_packer_if.sv
// Host-side packed-word stream: FIFO head word with valid/ready handshake.
interface nmr_echo_packer_if;

  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport master (output OUT_DATA, output OUT_VALID, input OUT_READY);
  modport slave  (input OUT_DATA, input OUT_VALID, output OUT_READY);

endinterface

// File: rtl/nmr_echo_packer_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module nmr_sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // level never exceeds DEPTH, so its top bit alone marks full
  assign full     = level[DEPTH_LOG2];
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nmr_echo_packer.sv
// Frames ADC samples per echo/scan, packs sample pairs into 32-bit words and buffers them for the host.
// Optional per-echo header words and SAMPLE_LOST port: define NMR_ECHO_PACKER_HEADER_EN.
module nmr_echo_packer
  import nmr_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH         = 16,
  parameter int unsigned SAMPLES_PER_ECHO_WIDTH = 32,
  parameter int unsigned ECHO_PER_SCAN_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH_LOG2        = 6
) (
  input  logic                              ADC_CLK,
  input  logic                              RESET,
  input  logic                              START,
  input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
  input  logic [ECHO_PER_SCAN_WIDTH-1:0]    ECHO_PER_SCAN,
  input  logic [ADC_DATA_WIDTH-1:0]         ADC_DATA_IN,
  input  logic                              ADC_DATA_VALID,
  nmr_echo_packer_if.master                 host,
  output logic                              BUSY,
  output logic                              SCAN_DONE,
  output logic                              OVERFLOW,
  output logic [FIFO_DEPTH_LOG2:0]          FIFO_LEVEL
`ifdef NMR_ECHO_PACKER_HEADER_EN
  ,
  output logic                              SAMPLE_LOST
`endif
);

  state_t                            state;
  logic [SAMPLES_PER_ECHO_WIDTH-1:0] spe_q;
  logic [ECHO_PER_SCAN_WIDTH-1:0]    epe_q;
  logic [SAMPLES_PER_ECHO_WIDTH-1:0] s_cnt;
  logic [ECHO_PER_SCAN_WIDTH-1:0]    echo_cnt;
  logic [ADC_DATA_WIDTH-1:0]         hold;

  logic        sample_last;
  logic        echo_last;
  logic        push_en;
  logic [31:0] push_word;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_data;

  assign sample_last = (s_cnt == spe_q - SAMPLES_PER_ECHO_WIDTH'(1));
  assign echo_last   = (echo_cnt == epe_q - ECHO_PER_SCAN_WIDTH'(1));
  assign pop         = host.OUT_VALID && host.OUT_READY;
  assign BUSY        = (state != IDLE);

  assign host.OUT_VALID = !fifo_empty;
  assign host.OUT_DATA  = fifo_data;

  // Push is decided in the sample's own cycle so the word lands on that edge.
  always_comb begin
    push_en   = 1'b0;
    push_word = '0;
    case (state)
`ifdef NMR_ECHO_PACKER_HEADER_EN
      HDR: begin
        push_en   = 1'b1;
        push_word = {HEADER_TAG, echo_cnt[15:0]};
      end
`endif
      ACQ: begin
        if (ADC_DATA_VALID) begin
          if (s_cnt[0]) begin
            push_en   = 1'b1;
            push_word = {ADC_DATA_IN, hold};
          end else if (sample_last) begin
            push_en   = 1'b1;
            push_word = {PAD_WORD_HALF, ADC_DATA_IN};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ADC_CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      spe_q       <= '0;
      epe_q       <= '0;
      s_cnt       <= '0;
      echo_cnt    <= '0;
      hold        <= '0;
      SCAN_DONE   <= 1'b0;
      OVERFLOW    <= 1'b0;
`ifdef NMR_ECHO_PACKER_HEADER_EN
      SAMPLE_LOST <= 1'b0;
`endif
    end else begin
      SCAN_DONE <= 1'b0;
      if (push_en && fifo_full && !pop) begin
        OVERFLOW <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (START) begin
            spe_q    <= SAMPLES_PER_ECHO;
            epe_q    <= ECHO_PER_SCAN;
            s_cnt    <= '0;
            echo_cnt <= '0;
            OVERFLOW <= 1'b0;
`ifdef NMR_ECHO_PACKER_HEADER_EN
            SAMPLE_LOST <= 1'b0;
`endif
            if (SAMPLES_PER_ECHO == '0 || ECHO_PER_SCAN == '0) begin
              state <= DONE;
            end else begin
`ifdef NMR_ECHO_PACKER_HEADER_EN
              state <= HDR;
`else
              state <= ACQ;
`endif
            end
          end
        end
`ifdef NMR_ECHO_PACKER_HEADER_EN
        HDR: begin
          if (ADC_DATA_VALID) begin
            SAMPLE_LOST <= 1'b1;
          end
          state <= ACQ;
        end
`endif
        ACQ: begin
          if (ADC_DATA_VALID) begin
            if (!s_cnt[0]) begin
              hold <= ADC_DATA_IN;
            end
            if (sample_last) begin
              s_cnt    <= '0;
              echo_cnt <= echo_cnt + 1'b1;
              if (echo_last) begin
                state <= DONE;
              end else begin
`ifdef NMR_ECHO_PACKER_HEADER_EN
                state <= HDR;
`else
                state <= ACQ;
`endif
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          SCAN_DONE <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  nmr_sync_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (ADC_CLK),
    .rst       (RESET),
    .push      (push_en),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (FIFO_LEVEL)
  );

endmodule

// File: tb/tb_nmr_echo_packer.sv
// Scoreboard bench for nmr_echo_packer: expected words come from a list-based framing model.
module tb_nmr_echo_packer;

`ifdef NMR_ECHO_PACKER_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        start    = 1'b0;
  logic [31:0] spe_in   = '0;
  logic [31:0] epe_in   = '0;
  logic [15:0] adc      = '0;
  logic        adc_v    = 1'b0;
  logic        busy;
  logic        scan_done;
  logic        overflow;
  logic [6:0]  level;
`ifdef NMR_ECHO_PACKER_HEADER_EN
  logic        sample_lost;
`endif

  nmr_echo_packer_if host_if ();

  nmr_echo_packer #(
    .ADC_DATA_WIDTH         (16),
    .SAMPLES_PER_ECHO_WIDTH (32),
    .ECHO_PER_SCAN_WIDTH    (32),
    .FIFO_DEPTH_LOG2        (6)
  ) dut (
    .ADC_CLK          (clk),
    .RESET            (rst),
    .START            (start),
    .SAMPLES_PER_ECHO (spe_in),
    .ECHO_PER_SCAN    (epe_in),
    .ADC_DATA_IN      (adc),
    .ADC_DATA_VALID   (adc_v),
    .host             (host_if),
    .BUSY             (busy),
    .SCAN_DONE        (scan_done),
    .OVERFLOW         (overflow),
    .FIFO_LEVEL       (level)
`ifdef NMR_ECHO_PACKER_HEADER_EN
    ,
    .SAMPLE_LOST      (sample_lost)
`endif
  );

  always #5 clk = ~clk;

  int          checks    = 0;
  int          errors    = 0;
  int          done_seen = 0;
  int          done_exp  = 0;
  int          popped    = 0;
  int          rdy_mode  = 0;
  logic [31:0] exp_q [$];
  logic [15:0] stim  [$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Framing rule: per echo an optional header, then samples paired low-first, odd tail padded high.
  function automatic int model_scan(input int unsigned spe, input int unsigned epe, input int keep);
    int n = 0;
    for (int unsigned e = 0; e < epe; e++) begin
      if (HDR_WORDS == 1) begin
        if (keep < 0 || n < keep) exp_q.push_back({16'hEC40, 16'(e)});
        n++;
      end
      for (int unsigned i = 0; i < spe; i += 2) begin
        logic [15:0] lo;
        logic [15:0] hi;
        lo = stim[e*spe + i];
        hi = (i + 1 < spe) ? stim[e*spe + i + 1] : 16'h0000;
        if (keep < 0 || n < keep) exp_q.push_back({hi, lo});
        n++;
      end
    end
    return (keep >= 0 && n > keep) ? keep : n;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       host_if.OUT_READY = 1'b1;
        1:       host_if.OUT_READY = 1'($urandom_range(0, 1));
        default: host_if.OUT_READY = 1'b0;
      endcase
    end
  end

  initial begin
    logic [31:0] req;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (scan_done) done_seen++;
        if (host_if.OUT_VALID && host_if.OUT_READY) begin
          popped++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL word actual=%08h required=none", host_if.OUT_DATA);
          end else begin
            req = exp_q.pop_front();
            if (host_if.OUT_DATA !== req) begin
              errors++;
              $display("FAIL word actual=%08h required=%08h", host_if.OUT_DATA, req);
            end
          end
        end
      end
    end
  end

  task automatic wait_done();
    int i = 0;
    while (done_seen < done_exp && i < 20) begin
      tick();
      i++;
    end
    chk("scan_done_count", longint'(done_seen), longint'(done_exp));
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((exp_q.size() != 0 || level != 0) && i < 3000) begin
      tick();
      i++;
    end
    chk("drain_queue", longint'(exp_q.size()), 0);
    chk("drain_level", level, 0);
  endtask

  // Consumes stim; one idle cycle after START and after each echo leaves room for headers.
  task automatic run_scan(input int unsigned spe, input int unsigned epe, input int max_gap,
                          input int keep, input int ovf_at, input bit exp_ovf, input bit inject,
                          output int words);
    int fed = 0;
    words = model_scan(spe, epe, keep);
    spe_in = spe;
    epe_in = epe;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    if (inject) begin
      adc   = 16'hDEAD;
      adc_v = 1'b1;
    end
    tick();
    adc_v = 1'b0;
`ifdef NMR_ECHO_PACKER_HEADER_EN
    chk("sample_lost", sample_lost, inject);
`endif
    for (int unsigned e = 0; e < epe; e++) begin
      for (int unsigned i = 0; i < spe; i++) begin
        repeat ($urandom_range(0, max_gap)) tick();
        adc   = stim[e*spe + i];
        adc_v = 1'b1;
        tick();
        adc_v = 1'b0;
        fed++;
        if (ovf_at > 0 && fed == ovf_at) begin
          chk("level_at_full", level, 64);
          chk("ovf_before_65th", overflow, 0);
        end
        if (ovf_at > 0 && fed == ovf_at + 2) begin
          chk("level_saturated", level, 64);
          chk("ovf_at_65th", overflow, 1);
        end
      end
      tick();
    end
    done_exp++;
    wait_done();
    chk("busy_after_scan", busy, 0);
    chk("overflow_flag", overflow, exp_ovf);
    stim.delete();
  endtask

  initial begin
    int base;
    int words;
    int spe_r;
    int epe_r;

    repeat (3) tick();
    chk("rst_valid", host_if.OUT_VALID, 0);
    chk("rst_data", host_if.OUT_DATA, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", scan_done, 0);
    chk("idle_ovf", overflow, 0);
    chk("idle_level", level, 0);
    chk("idle_valid", host_if.OUT_VALID, 0);

    // 30 x 5 back-to-back samples 100,101,...
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) stim.push_back(16'(100 + i));
    base = popped;
    run_scan(30, 5, 0, -1, 0, 1'b0, 1'b0, words);
    wait_drain();
    chk("t1_words", longint'(popped - base), longint'(75 + 5*HDR_WORDS));

    // odd echo length pads the tail
    for (int i = 1; i <= 6; i++) stim.push_back(16'(i));
    base = popped;
    run_scan(3, 2, 1, -1, 0, 1'b0, 1'b0, words);
    wait_drain();
    chk("t2_words", longint'(popped - base), longint'(4 + 2*HDR_WORDS));

    // overflow: 100 words into a 64-deep FIFO with the consumer stalled
    rdy_mode = 2;
    tick();
    tick();
    for (int i = 0; i < 200; i++) stim.push_back(16'(i*3 + 1));
    base = popped;
    run_scan(200, 1, 0, 64, 128 - 2*HDR_WORDS, 1'b1, 1'b0, words);
    chk("t3_level", level, 64);
    rdy_mode = 0;
    wait_drain();
    chk("t3_words", longint'(popped - base), 64);

    // zero counts go straight to DONE
    for (int k = 0; k < 2; k++) begin
      spe_in = (k == 0) ? 32'd4 : 32'd0;
      epe_in = (k == 0) ? 32'd0 : 32'd3;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk("zero_busy1", busy, 1);
      chk("zero_done1", scan_done, 0);
      tick();
      chk("zero_busy2", busy, 0);
      chk("zero_done2", scan_done, 1);
      tick();
      chk("zero_done3", scan_done, 0);
      chk("zero_level", level, 0);
      done_exp++;
      chk("zero_done_count", longint'(done_seen), longint'(done_exp));
    end

    // reset in the middle of acquisition
    rdy_mode = 2;
    tick();
    tick();
    spe_in = 100;
    epe_in = 1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      adc   = 16'(500 + i);
      adc_v = 1'b1;
      tick();
    end
    adc_v = 1'b0;
    chk("t5_level_pre", level, longint'(10 + HDR_WORDS));
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    chk("t5_valid", host_if.OUT_VALID, 0);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b0;
    tick();
    rdy_mode = 0;
    stim.push_back(16'd7);
    stim.push_back(16'd8);
    run_scan(2, 1, 0, -1, 0, 1'b0, 1'b0, words);
    wait_drain();

`ifdef NMR_ECHO_PACKER_HEADER_EN
    for (int i = 1; i <= 4; i++) stim.push_back(16'(i));
    run_scan(2, 2, 0, -1, 0, 1'b0, 1'b0, words);
    wait_drain();
    stim.push_back(16'd5);
    stim.push_back(16'd6);
    run_scan(2, 1, 0, -1, 0, 1'b0, 1'b1, words);
    wait_drain();
`endif

    // randomized scans with a stuttering consumer
    rdy_mode = 1;
    for (int r = 0; r < 6; r++) begin
      spe_r = $urandom_range(1, 9);
      epe_r = $urandom_range(1, 4);
      for (int i = 0; i < spe_r*epe_r; i++) stim.push_back(16'($urandom));
      base = popped;
      run_scan(spe_r, epe_r, 2, -1, 0, 1'b0, 1'b0, words);
      wait_drain();
      chk("rand_words", longint'(popped - base), longint'(words));
    end

    repeat (5) tick();
    chk("final_done_count", longint'(done_seen), longint'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nmr_echo_packer.md
Name: nmr_echo_packer

Overview:
- Receive-side consumer of the NMR controller's acquisition stream. It accepts 16-bit ADC samples qualified by a valid strobe and frames them per echo and per scan, using SAMPLES_PER_ECHO and ECHO_PER_SCAN.
- It packs sample pairs into 32-bit words and buffers them in an internal FIFO. The FIFO drains to the host/DMA side through a valid/ready interface.
- Sits between NMR_Controller (ADC_OUT_DATA/ADC_DATA_VALID) and the host data path, in the ADC_CLK domain.

Parameters:
- ADC_DATA_WIDTH, 16, sample width; must be 16.
- SAMPLES_PER_ECHO_WIDTH, 32, width of the samples-per-echo count.
- ECHO_PER_SCAN_WIDTH, 32, width of the echo count.
- FIFO_DEPTH_LOG2, 6, FIFO depth is 2^FIFO_DEPTH_LOG2 words (64).

Ports:
- ADC_CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle arm pulse; ignored unless in IDLE.
- SAMPLES_PER_ECHO  in  SAMPLES_PER_ECHO_WIDTH  samples per echo; sampled on START.
- ECHO_PER_SCAN  in  ECHO_PER_SCAN_WIDTH  echoes per scan; sampled on START.
- ADC_DATA_IN  in  16  sample from NMR_Controller.
- ADC_DATA_VALID  in  1  sample qualifier.
- OUT_DATA  out  32  FIFO head word.
- OUT_VALID  out  1  FIFO not empty.
- OUT_READY  in  1  consumer accepts OUT_DATA.
- BUSY  out  1  high when not in IDLE.
- SCAN_DONE  out  1  one-cycle pulse at scan completion.
- OVERFLOW  out  1  sticky: a word was dropped because the FIFO was full.
- FIFO_LEVEL  out  FIFO_DEPTH_LOG2+1  current word count.

Behaviour:
- Reset values: all outputs 0, FIFO empty, counters 0, state IDLE. Reset mid-scan aborts the scan and discards all buffered data.
- States and transitions:
  - IDLE: on START, latch both counts and clear OVERFLOW. If either count is 0, go to DONE; otherwise go to ACQ.
  - ACQ: runs the packing below. The final word of the final echo goes to DONE.
  - DONE: pulses SCAN_DONE for one cycle, then returns to IDLE.
  - FIFO draining is independent of state.
- Packing, per echo: a sample counter s runs 0..SAMPLES_PER_ECHO-1.
  - Even s: the sample goes into a holding register at bits [15:0].
  - Odd s: push {sample, hold} as one word.
  - If SAMPLES_PER_ECHO is odd, the last sample pushes {16'h0000, sample} immediately.
  - On the last sample, s wraps to 0 and the echo counter increments. The hold register never carries across echoes.
  - ADC_DATA_VALID outside ACQ is ignored.
- FIFO: first-word-fall-through, so OUT_DATA is valid whenever OUT_VALID is high.
  - Pop when OUT_VALID && OUT_READY.
  - Push when full: the word is dropped and OVERFLOW is set, unless a pop occurs in the same cycle, in which case the push succeeds.
  - Push and pop in the same cycle leave FIFO_LEVEL unchanged.
  - Push-to-OUT_VALID latency when empty: 1 cycle.
- Counter arithmetic is unsigned and full width; the echo counter is compared for equality, so there is no wrap inside a scan.
- SCAN_DONE fires 1 cycle after the final push attempt, regardless of FIFO drain or overflow.
- Data stays readable after DONE. A new START while the FIFO is non-empty is allowed and appends.

Optional Feature:
- Macro: NMR_ECHO_PACKER_HEADER_EN.
- When defined:
  - State HDR is added, entered from IDLE on START (for non-zero counts) and after each non-final echo completes.
  - HDR lasts 1 cycle and pushes header {16'hEC40, echo_index[15:0]}, with echo_index counting from 0, then enters ACQ.
  - ADC_DATA_VALID during HDR discards the sample and sets a sticky SAMPLE_LOST output, cleared on START. The controller's 180-degree pulse gap guarantees at least 1 idle cycle between echoes.
- When undefined: no HDR state, no SAMPLE_LOST port, behaviour exactly as above.

Decomposition:
- Package nmr_pkg:
  - State enum (IDLE, HDR, ACQ, DONE).
  - HEADER_TAG = 16'hEC40.
  - PAD_WORD_HALF = 16'h0000.
- Sub-module nmr_sync_fifo: single-clock first-word-fall-through FIFO, parameterised by width and depth log2, exposing full/empty/level. The packer FSM and counters stay in the top module.

Test Plan:
1. SAMPLES_PER_ECHO=30, ECHO_PER_SCAN=5, samples 100,101,... every cycle, OUT_READY=1 -> 75 words; first word 0x00650064; SCAN_DONE once; OVERFLOW=0.
2. SAMPLES_PER_ECHO=3, ECHO_PER_SCAN=2, samples 1..6 -> words 0x00020001, 0x00000003, 0x00050004, 0x00000006.
3. OUT_READY=0, SAMPLES_PER_ECHO=200, ECHO_PER_SCAN=1 -> FIFO_LEVEL saturates at 64; OVERFLOW sets on the 65th push; the 64 retained words are the first 64, in order.
4. ECHO_PER_SCAN=0 with START -> SCAN_DONE 2 cycles after START, no words; BUSY high for 1 cycle.
5. RESET asserted mid-ACQ after 10 words -> next edge: OUT_VALID=0, FIFO_LEVEL=0, BUSY=0; a following START with samples 7,8 yields 0x00080007.
6. With NMR_ECHO_PACKER_HEADER_EN, SAMPLES_PER_ECHO=2, ECHO_PER_SCAN=2 -> words 0xEC400000, data, 0xEC400001, data. A sample injected during HDR sets SAMPLE_LOST.
